change_capture: RTL

- Writer/recorder counterpart to the timing benches' expected-value replay: watches a bus of bit inputs and, while armed, emits one timestamped record per change.
- Each record is {timestamp, bit values}, the same row shape the expected CSV files use.
- Records are buffered in an internal first-word-fall-through FIFO and drained over a valid/ready port.
- Sits between block outputs under observation and a capture/readback path.

---
 rtl/change_capture.sv | 134 +++++++++++++
 1 files changed

// File: rtl/change_capture.sv
// Change recorder: while armed, emits one {timestamp, bits} record per change of bits_i into a FWFT FIFO.
// Optional build macro CHANGE_CAPTURE_TS_SAT_EN makes the timestamp saturate instead of wrapping.
module change_capture #(
  parameter int NBITS    = 4,
  parameter int TS_WIDTH = 32,
  parameter int DEPTH    = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       ENABLE_i,
  input  logic [NBITS-1:0]           bits_i,
  output logic                       dout_valid_o,
  input  logic                       dout_ready_i,
  output logic [TS_WIDTH-1:0]        dout_ts_o,
  output logic [NBITS-1:0]           dout_bits_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic                       active_o,
  output logic                       ts_sat_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = TS_WIDTH + NBITS;

  typedef enum logic [1:0] {IDLE, ARMED, OVERFLOW} state_t;

  state_t              state_q, state_d;
  logic                enable_q;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [NBITS-1:0]    last_q, last_d;
  logic                overflow_q, overflow_d;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q, wr_addr;
  logic [CW-1:0]       count_q;
  logic [RW-1:0]       mem [DEPTH];
  logic [RW-1:0]       wr_rec, head;
  logic                arm, flush, wr_en, pop, full;

  function automatic logic [TS_WIDTH-1:0] ts_step(input logic [TS_WIDTH-1:0] ts);
`ifdef CHANGE_CAPTURE_TS_SAT_EN
    ts_step = (&ts) ? ts : ts + TS_WIDTH'(1);
`else
    ts_step = ts + TS_WIDTH'(1);
`endif
  endfunction

  assign arm  = ENABLE_i && !enable_q;
  assign full = (count_q == CW'(DEPTH));
  assign pop  = (count_q != '0) && dout_ready_i;

  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q;
    last_d     = last_q;
    overflow_d = overflow_q;
    flush      = 1'b0;
    wr_en      = 1'b0;
    wr_rec     = {ts_q, bits_i};
    if (arm) begin
      flush      = 1'b1;
      wr_en      = 1'b1;
      wr_rec     = {{TS_WIDTH{1'b0}}, bits_i};
      ts_d       = TS_WIDTH'(1);
      last_d     = bits_i;
      overflow_d = 1'b0;
      state_d    = ARMED;
    end else if (!ENABLE_i) begin
      state_d = IDLE;
    end else if (state_q == ARMED) begin
      ts_d   = ts_step(ts_q);
      last_d = bits_i;
      if (bits_i != last_q) begin
        // A full FIFO drops the write even when the head pops on this edge.
        if (full) begin
          overflow_d = 1'b1;
          state_d    = OVERFLOW;
        end else begin
          wr_en = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      enable_q   <= 1'b0;
      ts_q       <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      enable_q   <= ENABLE_i;
      ts_q       <= ts_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
      if (flush) begin
        // Arm restarts the FIFO holding only the new {0, bits} record in slot 0.
        rd_ptr_q <= '0;
        wr_ptr_q <= AW'(1);
        count_q  <= CW'(1);
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + CW'(wr_en) - CW'(pop);
      end
    end
  end

  assign wr_addr = flush ? '0 : wr_ptr_q;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_rec;
  end

  assign head         = mem[rd_ptr_q];
  assign dout_valid_o = (count_q != '0);
  assign dout_ts_o    = dout_valid_o ? head[RW-1:NBITS] : '0;
  assign dout_bits_o  = dout_valid_o ? head[NBITS-1:0] : '0;
  assign count_o      = count_q;
  assign overflow_o   = overflow_q;
  assign active_o     = (state_q == ARMED);

`ifdef CHANGE_CAPTURE_TS_SAT_EN
  // Once saturated, ts_q stays all-ones until the next arm or reset.
  assign ts_sat_o = &ts_q;
`else
  assign ts_sat_o = 1'b0;
`endif

endmodule
